// File: rtl/count_check_pkg.sv
// rtl/count_check_pkg.sv - shared types and constants for the counter sequence checker
package count_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } count_check_state_t;

    localparam int STEP_DEFAULT   = 2;
    localparam int LOCK_N_DEFAULT = 3;
    localparam int ERR_MAX        = 255;
    localparam int ERR_W          = $clog2(ERR_MAX + 1);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - increment-enable counter that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on request, holding once every bit is set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/count_check.sv
// rtl/count_check.sv - lock-and-track checker for a free-running counter bus
module count_check
    import count_check_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP   = STEP_DEFAULT,
    parameter int LOCK_N = LOCK_N_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      sample_count,
    output logic [WIDTH-1:0] expected
);

    count_check_state_t r_state, w_state_next;
    logic [3:0]       r_good, w_good_next;
    logic [WIDTH-1:0] r_expected, w_expected_next;
    logic [WIDTH-1:0] w_advance, w_rebase;
    logic             w_match, w_err_next;
    logic             r_err, r_locked;
    logic [15:0]      r_sample_count;

    // Prediction for the next edge either follows our own count or restarts from the bus.
    assign w_advance = r_expected + WIDTH'(STEP);
    assign w_rebase  = in + WIDTH'(STEP);
    assign w_match   = (in == r_expected);

    // Next-state, streak and prediction logic; the source free-runs, so the
    // prediction keeps advancing even on cycles with no valid sample.
    always_comb begin
        w_state_next    = r_state;
        w_good_next     = r_good;
        w_expected_next = w_advance;
        w_err_next      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_expected_next = r_expected;
                if (in_valid) begin
                    w_expected_next = w_rebase;
                    w_good_next     = 4'd0;
                    w_state_next    = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE, ST_LOST: begin
                if (in_valid) begin
                    if (w_match) begin
                        if ((r_good + 4'd1) == 4'(LOCK_N)) begin
                            w_good_next  = 4'd0;
                            w_state_next = ST_LOCKED;
                        end else begin
                            w_good_next = r_good + 4'd1;
                        end
                    end else begin
                        w_expected_next = w_rebase;
                        w_good_next     = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (in_valid && !w_match) begin
                    w_err_next      = 1'b1;
                    w_expected_next = w_rebase;
                    w_good_next     = 4'd0;
                    w_state_next    = ST_LOST;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, prediction and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_good         <= 4'd0;
            r_expected     <= '0;
            r_err          <= 1'b0;
            r_locked       <= 1'b0;
            r_sample_count <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_good     <= w_good_next;
            r_expected <= w_expected_next;
            r_err      <= w_err_next;
            r_locked   <= (w_state_next == ST_LOCKED);
            if (in_valid) begin
                r_sample_count <= r_sample_count + 16'd1;
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_count (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_err_next),
        .o_count (err_count)
    );

    assign locked       = r_locked;
    assign err          = r_err;
    assign sample_count = r_sample_count;
    assign expected     = r_expected;

endmodule

// File: tb/tb_count_check.sv
// tb/tb_count_check.sv - directed stimulus with a reference model for count_check
module tb_count_check;

    localparam int STEP   = 2;
    localparam int LOCK_N = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in = 8'd0;
    logic        in_valid = 1'b0;
    logic        locked;
    logic        err;
    logic [7:0]  err_count;
    logic [15:0] sample_count;
    logic [7:0]  expected;

    int n_chk = 0;
    int n_err = 0;
    int err_seen = 0;
    bit m_ready = 0;

    // Reference model: "started" means a baseline exists, "streak" counts correct steps.
    bit m_started = 0;
    bit m_locked = 0;
    bit m_err = 0;
    int m_streak = 0;
    int m_expected = 0;
    int m_errcnt = 0;
    int m_samples = 0;

    count_check u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in           (in),
        .in_valid     (in_valid),
        .locked       (locked),
        .err          (err),
        .err_count    (err_count),
        .sample_count (sample_count),
        .expected     (expected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit rst_n, input bit v, input int val);
        int pred;
        if (!rst_n) begin
            m_started = 0; m_locked = 0; m_err = 0; m_streak = 0;
            m_expected = 0; m_errcnt = 0; m_samples = 0;
            return;
        end
        m_err = 0;
        pred = m_expected;
        if (v) m_samples = (m_samples + 1) % 65536;
        if (!m_started) begin
            if (v) begin
                m_started  = 1;
                m_streak   = 0;
                m_expected = (val + STEP) % 256;
            end
            return;
        end
        m_expected = (pred + STEP) % 256;
        if (!v) return;
        if (val == pred) begin
            if (!m_locked) begin
                m_streak++;
                if (m_streak == LOCK_N) m_locked = 1;
            end
        end else begin
            if (m_locked) begin
                m_err = 1;
                m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
            end
            m_locked   = 0;
            m_streak   = 0;
            m_expected = (val + STEP) % 256;
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input int val);
        reset_n  = rst_n;
        in_valid = v;
        in       = 8'(val % 256);
        @(posedge clk);
        model_update(rst_n, v, val % 256);
        m_ready = 1;
        #1;
    endtask

    // Every cycle after the first reset edge, the DUT must match the model.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("err", 32'(err), 32'(m_err));
            chk("locked", 32'(locked), 32'(m_locked));
            chk("err_count", 32'(err_count), 32'(m_errcnt));
            chk("sample_count", 32'(sample_count), 32'(m_samples));
            chk("expected", 32'(expected), 32'(m_expected));
            if (err === 1'b1) err_seen++;
        end
    end

    initial begin
        int v;
        int x;

        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sample_count", 32'(sample_count), 0);
        chk("rst_expected", 32'(expected), 0);
        chk("rst_err_count", 32'(err_count), 0);

        for (int i = 0; i < 4; i++) step(1, 1, 10 + 2 * i);
        chk("clean_locked", 32'(locked), 1);
        chk("clean_sample_count", 32'(sample_count), 4);
        chk("clean_expected", 32'(expected), 18);

        for (int i = 0; i <= 120; i++) step(1, 1, (18 + 2 * i) % 256);
        chk("wrap_locked", 32'(locked), 1);
        chk("wrap_expected", 32'(expected), 4);
        chk("wrap_err_count", 32'(err_count), 0);

        for (int i = 0; i < 18; i++) step(1, 1, 4 + 2 * i);
        step(1, 1, 50);
        chk("inject_err", 32'(err), 1);
        chk("inject_err_count", 32'(err_count), 1);
        chk("inject_locked", 32'(locked), 0);
        step(1, 1, 52);
        chk("inject_err_cleared", 32'(err), 0);
        step(1, 1, 54);
        step(1, 1, 56);
        chk("relock_locked", 32'(locked), 1);

        step(1, 1, 58);
        step(1, 0, 99);
        step(1, 0, 7);
        step(1, 0, 64);
        step(1, 1, 66);
        step(1, 1, 68);
        chk("gap_locked", 32'(locked), 1);
        chk("gap_sample_count", 32'(sample_count), 150);
        chk("gap_err_count", 32'(err_count), 1);

        v = 70;
        for (int k = 0; k < 300; k++) begin
            x = (v + 10) % 256;
            step(1, 1, x);
            for (int j = 1; j <= 3; j++) step(1, 1, (x + 2 * j) % 256);
            v = (x + 8) % 256;
        end
        chk("sat_err_count", 32'(err_count), 255);
        chk("sat_err_pulses", 32'(err_seen), 301);
        chk("sat_sample_count", 32'(sample_count), 1350);

        step(0, 0, 0);
        step(1, 1, 100);
        step(1, 1, 102);
        step(1, 1, 104);
        step(1, 1, 107);
        chk("acq_mismatch_no_err", 32'(err), 0);
        chk("acq_mismatch_expected", 32'(expected), 109);
        step(1, 1, 109);
        step(1, 1, 111);
        step(1, 1, 113);
        chk("acq_relock", 32'(locked), 1);
        v = 115;
        for (int k = 0; k < 7; k++) begin
            x = (v + 10) % 256;
            step(1, 1, x);
            for (int j = 1; j <= 3; j++) step(1, 1, (x + 2 * j) % 256);
            v = (x + 8) % 256;
        end
        chk("pre_reset_err_count", 32'(err_count), 7);
        chk("pre_reset_locked", 32'(locked), 1);

        step(0, 1, 200);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_err_count", 32'(err_count), 0);
        chk("mid_rst_sample_count", 32'(sample_count), 0);
        chk("mid_rst_expected", 32'(expected), 0);
        step(1, 0, 33);
        chk("idle_hold_expected", 32'(expected), 0);

        step(1, 1, 40);
        step(1, 1, 42);
        step(1, 1, 44);
        step(1, 1, 46);
        step(1, 1, 60);
        chk("flight_err", 32'(err), 1);
        step(0, 0, 0);
        chk("flight_err_dropped", 32'(err), 0);

        @(negedge clk);
        m_ready = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/count_check.md
# count_check

Sampling checker for the free-running dual-edge counter bus. It samples an up-counter bus on the rising edge of `clk`. That counter increments on both clock edges, so a healthy bus advances by `STEP` (mod 2^`WIDTH`) between consecutive rising edges. The block acquires lock on the sequence, then flags every deviation and keeps error and sample statistics. It sits on the consumer side of the counter and serves as a self-checking monitor in simulation and bring-up builds.

## Interface
- `WIDTH`, 8: width of the observed counter bus.
- `STEP`, 2: expected increment per rising edge of `clk`.
- `LOCK_N`, 3: consecutive correct steps required to declare lock (1..15).
- `clk`  input  1  clock; all state updates on rising edge only.
- `reset_n`  input  1  reset: synchronous, active-low.
- `in`  input  `WIDTH`  observed counter value.
- `in_valid`  input  1  `in` is meaningful this cycle.
- `locked`  output  1  sequence tracked and confirmed.
- `err`  output  1  one-cycle pulse: mismatch detected while locked.
- `err_count`  output  8  mismatches while locked, saturates at 255.
- `sample_count`  output  16  valid samples accepted, wraps at 2^16.
- `expected`  output  `WIDTH`  value predicted for the current cycle.

## Operation
- FSM states: IDLE, ACQUIRE, LOCKED, LOST.
- IDLE: wait for `in_valid`. On the first valid sample, capture `expected <= in + STEP`, clear `good`, go to ACQUIRE.
- `expected` advances by `STEP` every cycle once out of IDLE, whether or not `in_valid` is high. The source free-runs. Arithmetic is modulo 2^`WIDTH`, so with default parameters 255 → 1 is a correct step.
- ACQUIRE, valid sample:
  - If `in == expected`: `good++`. When `good` reaches `LOCK_N`, go to LOCKED.
  - Otherwise: rebaseline with `expected <= in + STEP` and `good <= 0`. No `err` pulse.
- LOCKED, valid sample with `in != expected`:
  - Pulse `err`, increment `err_count` (saturating), go to LOST.
  - Rebaseline `expected` from `in` as in ACQUIRE.
- LOST: behaves exactly like ACQUIRE, except `locked` stays 0. It reaches LOCKED again after `LOCK_N` consecutive correct steps.
- `in_valid` low in any state: no check, `good` unchanged, `sample_count` unchanged.
- `sample_count` increments on every valid sample in every state, including the first sample in IDLE.
- Reset mid-operation: all state returns to reset values on the next rising edge. The `err` pulse in flight is dropped.

## Timing
- Reset values:
  - `locked` = 0, `err` = 0, `err_count` = 0, `sample_count` = 0, `expected` = 0.
  - FSM = IDLE, `good` = 0.
- All outputs are registered. A sample seen at edge k is reflected in `err`, `locked`, counters and `expected` immediately after edge k. There is no further pipelining.
- `err` is high for exactly one cycle per mismatch. A mismatch on the sample that would otherwise complete lock in ACQUIRE or LOST produces no `err`.
- `locked` rises in the same cycle the FSM enters LOCKED. It falls in the same cycle `err` pulses.
- `err_count` at 255 stays 255 while `err` still pulses.
- Simultaneous `reset_n` low and `in_valid` high: reset wins and the sample is ignored.

## Structure
- Package `count_check_pkg` holds:
  - the state enum `count_check_state_t` (IDLE, ACQUIRE, LOCKED, LOST);
  - the default `STEP` and `LOCK_N` constants;
  - the `ERR_MAX` = 255 constant.
- Sub-module `sat_counter` provides a parameterised-width, increment-enable counter that saturates at all-ones with synchronous active-low reset. It is used for `err_count`.
- `good` is 4 bits wide.

## Test plan
- Reset then clean stream 10, 12, 14, 16 with `in_valid` = 1: `locked` = 1 after the 4th sample, `err` never high, `sample_count` = 4.
- Locked stream at 252, 254, 0, 2: wrap accepted, no `err`, `locked` stays 1.
- Locked stream, inject 50 where 40 is expected: `err` pulses 1 cycle, `err_count` = 1, `locked` = 0. Continue 52, 54, 56: `locked` = 1 again, with no further `err`.
- `in_valid` low for 3 cycles while source continues 20 → 28: no `err`, `locked` held, `sample_count` excludes the gap cycles.
- 300 forced mismatches, each followed by relock: `err_count` saturates at 255, and `err` still pulses on every mismatch.
- Assert `reset_n` = 0 for one cycle while LOCKED with `err_count` = 7: next cycle all outputs are 0 and the FSM is in IDLE.
